// File: rtl/tri_clip_queue.sv
// ---------------------------------------------------------------------------
// tri_clip_queue
//
// Triangle front end for the 3D pipeline. Pulls 32-bit words from the AHB
// read buffer and assembles them into triangles. Each triangle is ten words:
// three XYZ vertices, then one color. Each triangle is bounds-checked against
// the viewport under a run-time clip mode. Accepted triangles are queued in a
// DEPTH-entry show-ahead FIFO for the rasterizer. Rejected triangles are
// dropped and counted.
//
// Ports
//   clk                    system clock, rising edge
//   n_rst                  asynchronous active-low reset
//   ahb_buffer[31:0]       word at the head of the AHB read buffer
//   ahb_data_available     ahb_buffer holds a valid word
//   ahb_user_read_buffer   consume ahb_buffer this cycle
//   clip_mode[1:0]         0/3 pass all, 1 drop if all vertices out,
//                          2 drop if any vertex out
//   triangle_read          pop the FIFO head
//   triangle_vertices_out  FIFO head vertices, word (3i+c) at [(3i+c)*32 +: 32]
//   triangle_color_out     FIFO head color
//   triangle_ready         FIFO non-empty
//   fifo_count             entries held
//   drop_count             dropped triangles since reset, saturating
// ---------------------------------------------------------------------------
module tri_clip_queue #(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int Z_MAX    = 65535
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [31:0]                ahb_buffer,
    input  logic                       ahb_data_available,
    output logic                       ahb_user_read_buffer,
    input  logic [1:0]                 clip_mode,
    input  logic                       triangle_read,
    output logic [287:0]               triangle_vertices_out,
    output logic [31:0]                triangle_color_out,
    output logic                       triangle_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [31:0] X_LIM = 32'(SCREEN_W);
    localparam logic signed [31:0] Y_LIM = 32'(SCREEN_H);
    localparam logic signed [31:0] Z_LIM = 32'(Z_MAX);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        PUSH    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [31:0]    r_words [10];
    logic [3:0]     r_idx;

    logic [287:0]   r_fifo_vert  [DEPTH];
    logic [31:0]    r_fifo_color [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_drop_count;

    logic           w_take;
    logic           w_drop;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_reject;
    logic [2:0]     w_vert_out;
    logic [287:0]   w_tri_vert;

    // A vertex is out when any coordinate leaves its range. The compares
    // are signed, so negative coordinates count as out.
    always_comb begin
        w_vert_out = '0;
        for (int i = 0; i < 3; i++) begin
            w_vert_out[i] = ($signed(r_words[3*i])   < 0) || ($signed(r_words[3*i])   >= X_LIM) ||
                            ($signed(r_words[3*i+1]) < 0) || ($signed(r_words[3*i+1]) >= Y_LIM) ||
                            ($signed(r_words[3*i+2]) < 0) || ($signed(r_words[3*i+2]) >  Z_LIM);
        end
    end

    always_comb begin
        w_reject = 1'b0;
        case (clip_mode)
            2'd1:    w_reject = &w_vert_out;
            2'd2:    w_reject = |w_vert_out;
            default: w_reject = 1'b0;
        endcase
    end

    always_comb begin
        w_tri_vert = '0;
        for (int k = 0; k < 9; k++) begin
            w_tri_vert[k*32 +: 32] = r_words[k];
        end
    end

    // Full is judged on the registered count, so a pop in the same cycle
    // does not let a stalled triangle in until the next edge.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = triangle_read && (r_count != '0);

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_drop       = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            COLLECT: begin
                w_take = ahb_data_available;
                if (w_take && (r_idx == 4'd9)) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (w_reject) begin
                    w_drop       = 1'b1;
                    w_state_next = COLLECT;
                end else begin
                    w_state_next = PUSH;
                end
            end
            PUSH: begin
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= COLLECT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_idx <= (r_idx == 4'd9) ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

    // Word storage needs no reset: a reset rewinds r_idx, which discards
    // any partial triangle.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_words[r_idx] <= ahb_buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_vert[r_wr_ptr]  <= w_tri_vert;
            r_fifo_color[r_wr_ptr] <= r_words[9];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign ahb_user_read_buffer  = w_take;
    assign triangle_ready        = (r_count != '0);
    assign triangle_vertices_out = triangle_ready ? r_fifo_vert[r_rd_ptr]  : '0;
    assign triangle_color_out    = triangle_ready ? r_fifo_color[r_rd_ptr] : '0;
    assign fifo_count            = r_count;
    assign drop_count            = r_drop_count;

endmodule

// File: doc/tri_clip_queue.md
# tri_clip_queue

Parametrised triangle front end for the 3D pipeline, replacing the single-entry clip-and-split stage. Pulls 32-bit words from the AHB slave read buffer, assembles them into triangles (three XYZ vertices plus one color), bounds-checks each against a configurable viewport under a run-time clip mode, and queues accepted triangles in a DEPTH-entry FIFO for the rasterizer. Rejected triangles are dropped and counted.

## Interface
- DEPTH, 4, triangle FIFO entries; power of two, 2..16
- SCREEN_W, 640, x in-bounds iff 0 <= x < SCREEN_W
- SCREEN_H, 480, y in-bounds iff 0 <= y < SCREEN_H
- Z_MAX, 65535, z in-bounds iff 0 <= z <= Z_MAX
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- ahb_buffer  in  32  current word at head of AHB read buffer
- ahb_data_available  in  1  ahb_buffer holds a valid word
- ahb_user_read_buffer  out  1  consume ahb_buffer this cycle
- clip_mode  in  2  0 pass all, 1 drop if all three vertices out, 2 drop if any vertex out, 3 same as 0
- triangle_read  in  1  rasterizer pops FIFO head
- triangle_vertices_out  out  288  FIFO head vertices; vertex i coord c (x=0,y=1,z=2) at bits [(3i+c)*32 +: 32]
- triangle_color_out  out  32  FIFO head color
- triangle_ready  out  1  FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  entries held
- drop_count  out  16  triangles dropped since reset, saturating

## Operation
- Word order per triangle: v0.x, v0.y, v0.z, v1.x, v1.y, v1.z, v2.x, v2.y, v2.z, color (10 words). Coordinates are signed 32-bit two's complement.
- Assembler FSM: COLLECT, CHECK, PUSH.
  - COLLECT: ahb_user_read_buffer = ahb_data_available (combinational). On each cycle it is high, ahb_buffer is stored at word index idx, and idx increments. After idx 9 is stored, idx returns to 0 and state goes to CHECK.
  - CHECK (1 cycle, no reads): evaluate per-vertex out flag (any of x, y, z outside its range; signed compare, so negative values are out). Sample clip_mode. If dropped: drop_count += 1 (hold at 0xFFFF) and go to COLLECT. Otherwise go to PUSH.
  - PUSH: if fifo_count < DEPTH, write the triangle at wr_ptr and go to COLLECT. Otherwise stay in PUSH (back-pressure; no AHB reads).
- FIFO: show-ahead. Head appears on triangle_vertices_out/triangle_color_out while triangle_ready. Outputs are forced to 0 when empty.
  - triangle_read with triangle_ready pops the head. triangle_read when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged.
  - There is no push-when-full bypass. Full is judged on the registered fifo_count.
- Partial triangle words persist across idle cycles; no timeout.

## Timing
- Reset (async, n_rst low): state COLLECT, idx 0, FIFO empty, drop_count 0. All outputs 0 except ahb_user_read_buffer, which follows ahb_data_available.
- Reset mid-triangle or mid-PUSH discards the partial or pending triangle and clears the FIFO.
- Latency: last (color) word consumed on edge N → CHECK during cycle N+1 → PUSH writes on edge N+2 if not full → triangle_ready high after edge N+2 (when the FIFO was empty).
- Maximum throughput is one triangle per 12 cycles with continuous data.
- Pop takes effect on the clock edge; the next head is visible the following cycle.

## Test plan
- Reset, then 10 back-to-back words: v0 (10,20,30), v1 (100,200,300), v2 (5,5,5), color 0x00FF00FF, mode 0 -> triangle_ready rises 2 cycles after the color word is consumed; bits[31:0]=10, bits[287:256]=5, color 0x00FF00FF, fifo_count 1.
- Mode 2 with v1.x = 640 -> triangle dropped, drop_count 1, triangle_ready stays 0. Same triangle in mode 1 -> accepted. Mode 1 with all vertices at x = -1 -> dropped.
- DEPTH=4, no triangle_read, 5 valid triangles -> fifo_count 4; FSM holds in PUSH; ahb_user_read_buffer 0 despite ahb_data_available 1. One pop -> 5th triangle written next cycle, fifo_count returns to 4.
- FIFO at 2 entries, push and triangle_read in the same cycle -> fifo_count stays 2, head advances in order. Verify pointer wrap over 9 triangles.
- ahb_data_available toggled every other cycle during a triangle -> correct assembly; only words with ahb_user_read_buffer high are captured.
- n_rst asserted after 6 words and with 3 entries queued -> all outputs 0 immediately. The next 10 words form a fresh triangle from v0.x.
